// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: word width,
// operation encodings and small decode helpers.
package muldiv_unit_pkg;

  localparam int unsigned MD_WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_OP_MULT  = 2'b00,
    MD_OP_MULTU = 2'b01,
    MD_OP_DIV   = 2'b10,
    MD_OP_DIVU  = 2'b11
  } md_op_e;

  // Even encodings are the signed variants, the upper bit selects divide.
  function automatic logic md_op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic md_op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue / MTHI-MTLO / result bundle between the EX stage and muldiv_unit.
interface muldiv_unit_if
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = MD_WORD_WIDTH
);
  logic                  start;
  logic [1:0]            op;
  logic [WORD_WIDTH-1:0] src_a;
  logic [WORD_WIDTH-1:0] src_b;
  logic                  flush;
  logic                  hi_we;
  logic                  lo_we;
  logic [WORD_WIDTH-1:0] wdata;
  logic [WORD_WIDTH-1:0] hi;
  logic [WORD_WIDTH-1:0] lo;
  logic                  busy;
  logic                  done;

  modport master (
    output start, op, src_a, src_b, flush, hi_we, lo_we, wdata,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, src_a, src_b, flush, hi_we, lo_we, wdata,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit owning HI/LO; one step per
// cycle for WORD_WIDTH cycles, then a sign-fix/writeback cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = MD_WORD_WIDTH
)(
  input logic           clk,
  input logic           rst,
  muldiv_unit_if.slave  md
);

  localparam int unsigned CW = $clog2(WORD_WIDTH);
  localparam int unsigned W  = WORD_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e          state_q, state_n;
  logic [CW-1:0]   cnt_q;
  logic [2*W-1:0]  acc_q;
  logic [W-1:0]    opnd_q;
  logic [W-1:0]    a_raw_q;
  logic            is_div_q, neg_res_q, neg_rem_q, b_zero_q;
  logic [W-1:0]    hi_q, lo_q;
  logic            busy_q, done_q;

  logic            take_start, mt_write, write_result, last_step;
  logic            sgn, a_neg, b_neg;
  logic [W-1:0]    mag_a, mag_b;
  logic [W:0]      mul_sum, div_trial;
  logic [2*W-1:0]  mul_next, div_next, prod;
  logic [W-1:0]    quo, rem, res_hi, res_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n      = state_q;
    take_start   = 1'b0;
    mt_write     = 1'b0;
    write_result = 1'b0;
    last_step    = (cnt_q == CW'(W - 1));
    case (state_q)
      IDLE: begin
        take_start = md.start;
        mt_write   = ~md.start;
        if (md.start) state_n = RUN;
      end
      RUN: begin
        if (md.flush)     state_n = IDLE;
        else if (last_step) state_n = FIX;
      end
      FIX: begin
        write_result = ~md.flush;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operands are held as magnitudes; signs are reapplied in FIX.
  always_comb begin
    sgn   = md_op_is_signed(md.op);
    a_neg = sgn & md.src_a[W-1];
    b_neg = sgn & md.src_b[W-1];
    mag_a = a_neg ? -md.src_a : md.src_a;
    mag_b = b_neg ? -md.src_b : md.src_b;
  end

  // Multiply: multiplier in acc low half, shifts right as partial sums enter the top.
  // Divide: {remainder, dividend/quotient} shifts left, trial-subtracting the divisor.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opnd_q : {W{1'b0}})};
    mul_next  = {mul_sum, acc_q[W-1:1]};
    div_trial = acc_q[2*W-1:W-1] - {1'b0, opnd_q};
    div_next  = div_trial[W] ? {acc_q[2*W-2:0], 1'b0}
                             : {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
  end

  always_comb begin
    prod   = neg_res_q ? -acc_q : acc_q;
    quo    = neg_res_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem    = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
    res_hi = prod[2*W-1:W];
    res_lo = prod[W-1:0];
    if (is_div_q) begin
      res_hi = b_zero_q ? a_raw_q : rem;
      res_lo = b_zero_q ? '1      : quo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      busy_q <= (state_n != IDLE);
      done_q <= write_result;
      if (take_start) begin
        cnt_q     <= '0;
        is_div_q  <= md_op_is_div(md.op);
        neg_res_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        b_zero_q  <= (md.src_b == '0);
        a_raw_q   <= md.src_a;
        acc_q     <= md_op_is_div(md.op) ? {{W{1'b0}}, mag_a} : {{W{1'b0}}, mag_b};
        opnd_q    <= md_op_is_div(md.op) ? mag_b : mag_a;
      end
      if (state_q == RUN) begin
        cnt_q <= cnt_q + 1'b1;
        acc_q <= is_div_q ? div_next : mul_next;
      end
      if (write_result) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
      if (mt_write && md.hi_we) hi_q <= md.wdata;
      if (mt_write && md.lo_we) lo_q <= md.wdata;
    end
  end

  assign md.hi   = hi_q;
  assign md.lo   = lo_q;
  assign md.busy = busy_q;
  assign md.done = done_q;

endmodule
